// File: rtl/line_mem_model.sv
// line_mem_model: line-granular backing memory behind the D-cache.
// Whole-line reads, byte-masked line writes, fixed LATENCY, in-order
// completion, up to QDEPTH requests outstanding.
// Optional feature macro: MEM_WRITE_ACK_EN (write completions also pulse
// resp_valid with resp_is_write=1 and zero data).
module line_mem_model #(
    parameter int ADDR_W      = 32,
    parameter int LINE_BYTES  = 32,
    parameter int DEPTH_LINES = 1024,
    parameter int LATENCY     = 5,
    parameter int QDEPTH      = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_wen,
    input  logic [ADDR_W-1:0]       req_addr,
    input  logic [LINE_BYTES*8-1:0] req_wdata,
    input  logic [LINE_BYTES-1:0]   req_wstrb,
    output logic                    resp_valid,
    output logic [LINE_BYTES*8-1:0] resp_rdata,
    output logic                    resp_is_write,
    output logic                    busy
);
    localparam int LINE_W = LINE_BYTES * 8;
    localparam int OFF_W  = $clog2(LINE_BYTES);
    localparam int IDX_W  = $clog2(DEPTH_LINES);
    localparam int PTR_W  = $clog2(QDEPTH);
    localparam int CNT_W  = PTR_W + 1;
    // Stamp/counter width: just wide enough that the head's age never wraps
    // past LATENCY before it is seen.
    localparam int CW     = $clog2(LATENCY) + 1;

    typedef struct packed {
        logic                  wen;
        logic [IDX_W-1:0]      idx;
        logic [LINE_W-1:0]     wdata;
        logic [LINE_BYTES-1:0] wstrb;
        logic [CW-1:0]         stamp;
    } entry_t;

    logic [LINE_W-1:0] mem [DEPTH_LINES];
    entry_t            q   [QDEPTH];

    logic [CW-1:0]    cyc;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count, count_next;
    entry_t           head, new_e;
    logic [CW-1:0]    age;
    logic             accept, done;

    // Only the line-index bits of the address matter; the rest alias.
    logic unused_addr;
    assign unused_addr = ^req_addr;

    assign accept = req_valid && req_ready;
    assign head   = q[rd_ptr];
    assign age    = cyc - head.stamp;
    // Head completes once it has aged exactly LATENCY cycles; the response
    // registers below make that visible right after the completing edge.
    assign done   = (count != '0) && (age == CW'(LATENCY));
    assign busy   = (count != '0);

    // Build the queue entry for an incoming request.
    always_comb begin
        new_e       = '0;
        new_e.wen   = req_wen;
        new_e.idx   = req_addr[OFF_W+IDX_W-1:OFF_W];
        new_e.wdata = req_wdata;
        new_e.wstrb = req_wstrb;
        new_e.stamp = cyc;
    end

    // Occupancy after this edge; accept and complete together leave it unchanged.
    always_comb begin
        count_next = count;
        if (accept && !done)
            count_next = count + CNT_W'(1);
        else if (!accept && done)
            count_next = count - CNT_W'(1);
    end

    // Queue storage: payload only, validity is tracked by count/pointers.
    always_ff @(posedge clk) begin
        if (accept)
            q[wr_ptr] <= new_e;
    end

    // Byte-masked array update when a write reaches the head; a write caught
    // by reset never lands.
    always_ff @(posedge clk) begin
        if (done && head.wen && !rst) begin
            for (int b = 0; b < LINE_BYTES; b++) begin
                if (head.wstrb[b])
                    mem[head.idx][8*b +: 8] <= head.wdata[8*b +: 8];
            end
        end
    end

    // Queue control, cycle counter and registered response.
    always_ff @(posedge clk) begin
        if (rst) begin
            cyc        <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
`ifdef MEM_WRITE_ACK_EN
            resp_is_write <= 1'b0;
`endif
        end else begin
            cyc   <= cyc + CW'(1);
            count <= count_next;
            // Registered full flag: a completion this cycle does not let a
            // request in on the same edge.
            req_ready <= (count_next != CNT_W'(QDEPTH));
            if (accept)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (done)
                rd_ptr <= rd_ptr + PTR_W'(1);
            // Earlier writes have already been applied in order, so the array
            // line is up to date for a read at the head.
            resp_rdata <= (done && !head.wen) ? mem[head.idx] : '0;
`ifdef MEM_WRITE_ACK_EN
            resp_valid    <= done;
            resp_is_write <= done && head.wen;
`else
            resp_valid    <= done && !head.wen;
`endif
        end
    end

`ifndef MEM_WRITE_ACK_EN
    assign resp_is_write = 1'b0;
`endif

endmodule

// File: tb/tb_line_mem_model.sv
// tb_line_mem_model: directed checks of line_mem_model. Main instance uses
// default parameters; a second small instance (QDEPTH=2) covers queue-full.
module tb_line_mem_model;
    logic         clk = 1'b0;
    logic         rst = 1'b1;

    logic         req_valid = 1'b0, req_wen = 1'b0;
    logic [31:0]  req_addr = '0;
    logic [255:0] req_wdata = '0;
    logic [31:0]  req_wstrb = '0;
    logic         req_ready, resp_valid, resp_is_write, busy;
    logic [255:0] resp_rdata;

    logic         s_req_valid = 1'b0, s_req_wen = 1'b0;
    logic [31:0]  s_req_addr = '0;
    logic [31:0]  s_req_wdata = '0;
    logic [3:0]   s_req_wstrb = '0;
    logic         s_req_ready, s_resp_valid, s_resp_is_write, s_busy;
    logic [31:0]  s_resp_rdata;

    int n_chk = 0, n_err = 0, edge_n = 0;

    logic [255:0] rd_q[$];
    int           rd_e[$];
    logic [255:0] wr_d[$];
    int           wr_e[$];
    logic [31:0]  s_rd_q[$];
    int           s_rd_e[$];

    line_mem_model u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_is_write(resp_is_write), .busy(busy)
    );

    line_mem_model #(.ADDR_W(32), .LINE_BYTES(4), .DEPTH_LINES(16),
                     .LATENCY(5), .QDEPTH(2)) u_small (
        .clk(clk), .rst(rst),
        .req_valid(s_req_valid), .req_ready(s_req_ready), .req_wen(s_req_wen),
        .req_addr(s_req_addr), .req_wdata(s_req_wdata), .req_wstrb(s_req_wstrb),
        .resp_valid(s_resp_valid), .resp_rdata(s_resp_rdata),
        .resp_is_write(s_resp_is_write), .busy(s_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_n <= edge_n + 1;

    // Response capture, sampled mid-cycle.
    always @(negedge clk) begin
        if (resp_valid && !resp_is_write) begin
            rd_q.push_back(resp_rdata);
            rd_e.push_back(edge_n);
        end
        if (resp_valid && resp_is_write) begin
            wr_d.push_back(resp_rdata);
            wr_e.push_back(edge_n);
        end
        if (s_resp_valid) begin
            s_rd_q.push_back(s_resp_rdata);
            s_rd_e.push_back(edge_n);
        end
    end

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h exp %h", tag, got, exp);
        end
    endtask

    // Called at a negedge; leaves req_valid high so calls chain back-to-back.
    task automatic send(input logic wen, input logic [31:0] addr, input logic [255:0] wd,
                        input logic [31:0] st, output int acc);
        int g = 0;
        req_valid = 1'b1; req_wen = wen; req_addr = addr; req_wdata = wd; req_wstrb = st;
        while (!req_ready && g < 100) begin @(negedge clk); g++; end
        acc = edge_n + 1;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send_s(input logic wen, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [3:0] st, output int acc);
        int g = 0;
        s_req_valid = 1'b1; s_req_wen = wen; s_req_addr = addr; s_req_wdata = wd; s_req_wstrb = st;
        while (!s_req_ready && g < 100) begin @(negedge clk); g++; end
        acc = edge_n + 1;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        req_valid = 1'b0; req_wen = 1'b0;
        s_req_valid = 1'b0; s_req_wen = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        for (int g = 0; g < 100 && (busy || s_busy); g++) @(negedge clk);
        chk({tag, " idle"}, {busy, s_busy}, 2'b00);
        repeat (2) @(negedge clk);
    endtask

    task automatic clr();
        rd_q.delete(); rd_e.delete(); wr_d.delete(); wr_e.delete();
        s_rd_q.delete(); s_rd_e.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t, tw, tr;
        int acc[8];
        logic [31:0]  w;
        logic [255:0] pat;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst ready", req_ready, 1);
        chk("rst resp_valid", resp_valid, 0);
        chk("rst rdata", resp_rdata, 0);
        chk("rst is_write", resp_is_write, 0);
        chk("rst busy", busy, 0);
        chk("rst small ready", s_req_ready, 1);
        rst = 1'b0;
        @(negedge clk);

        // Read latency: preload line 0x80, read it back
        send(1'b1, 32'h1000, 256'hDDCCBBAA, 32'hFFFF_FFFF, t);
        idle();
        wait_idle("t1 pre");
        clr();
        send(1'b0, 32'h1000, '0, '0, t);
        idle();
        repeat (10) @(negedge clk);
        chk("t1 count", rd_q.size(), 1);
        chk("t1 edge", rd_e.size() > 0 ? rd_e[0] : -1, t + 5);
        chk("t1 data", rd_q.size() > 0 ? rd_q[0] : 'x, 256'hDDCCBBAA);

        // Masked write then read of the same line on the next cycle
        clr();
        send(1'b1, 32'h2000, 256'hDEADBEEF, 32'h0000_000F, tw);
        send(1'b0, 32'h2004, '0, '0, tr);
        idle();
        wait_idle("t2");
        chk("t2 b2b accept", tr, tw + 1);
        chk("t2 count", rd_q.size(), 1);
        chk("t2 edge", rd_e.size() > 0 ? rd_e[0] : -1, tw + 6);
        chk("t2 data", rd_q.size() > 0 ? rd_q[0] : 'x, 256'hDEADBEEF);
`ifdef MEM_WRITE_ACK_EN
        chk("t2 ack count", wr_e.size(), 1);
        chk("t2 ack edge", wr_e.size() > 0 ? wr_e[0] : -1, tw + 5);
        chk("t2 ack data", wr_d.size() > 0 ? wr_d[0] : 'x, 0);
`else
        chk("t2 no ack", wr_e.size(), 0);
`endif

        // Full throughput: 8 back-to-back writes, then 8 back-to-back reads
        for (int i = 0; i < 8; i++) begin
            w = 32'hC0DE_0000 + i;
            send(1'b1, 32'h0800 + 32 * i, {8{w}}, 32'hFFFF_FFFF, acc[i]);
        end
        idle();
        wait_idle("t3 pre");
        clr();
        for (int i = 0; i < 8; i++) send(1'b0, 32'h0800 + 32 * i, '0, '0, acc[i]);
        idle();
        wait_idle("t3");
        chk("t3 no stall", acc[7], acc[0] + 7);
        chk("t3 count", rd_q.size(), 8);
        for (int i = 0; i < 8; i++) begin
            w = 32'hC0DE_0000 + i;
            chk($sformatf("t3 edge%0d", i), i < rd_e.size() ? rd_e[i] : -1, acc[0] + 5 + i);
            chk($sformatf("t3 data%0d", i), i < rd_q.size() ? rd_q[i] : 'x, {8{w}});
        end

        // Queue full on the QDEPTH=2 instance
        for (int i = 0; i < 4; i++) send_s(1'b1, 4 * i, 32'h5A00_0000 + i, 4'hF, acc[i]);
        idle();
        wait_idle("t4 pre");
        clr();
        for (int i = 0; i < 4; i++) send_s(1'b0, 4 * i, '0, '0, acc[i]);
        idle();
        wait_idle("t4");
        chk("t4 acc1", acc[1], acc[0] + 1);
        chk("t4 acc2", acc[2], acc[0] + 6);
        chk("t4 acc3", acc[3], acc[0] + 7);
        chk("t4 count", s_rd_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t4 edge%0d", i), i < s_rd_e.size() ? s_rd_e[i] : -1, acc[i] + 5);
            chk($sformatf("t4 data%0d", i), i < s_rd_q.size() ? s_rd_q[i] : 'x, 32'h5A00_0000 + i);
        end

        // Aliasing: 0x8000 maps to the same line as 0x0000
        pat = {8{32'h1234_5678}} ^ 256'hF0;
        send(1'b1, 32'h0000, pat, 32'hFFFF_FFFF, t);
        idle();
        wait_idle("t5 pre");
        clr();
        send(1'b0, 32'h8000, '0, '0, t);
        idle();
        wait_idle("t5");
        chk("t5 count", rd_q.size(), 1);
        chk("t5 data", rd_q.size() > 0 ? rd_q[0] : 'x, pat);

        // Reset two cycles after accepting a write: write is dropped
        clr();
        send(1'b1, 32'h3000, '1, 32'hFFFF_FFFF, t);
        idle();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("t6 busy", busy, 0);
        chk("t6 ready", req_ready, 1);
        chk("t6 resp_valid", resp_valid, 0);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        chk("t6 no resp", rd_q.size() + wr_e.size(), 0);
        send(1'b0, 32'h3000, '0, '0, t);
        idle();
        wait_idle("t6");
        chk("t6 count", rd_q.size(), 1);
        chk("t6 edge", rd_e.size() > 0 ? rd_e[0] : -1, t + 5);
        chk("t6 data", rd_q.size() > 0 ? rd_q[0] : 'x, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end
endmodule
